// File: rtl/seg7_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver_pkg
//  Purpose  : Shared constants, types and helpers for the 4-digit
//             common-anode seven-segment scan driver.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_scan_driver_pkg;

    // Number of multiplexed digits on the display
    localparam int NUM_DIGITS = 4;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // All segments dark / all anodes released
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Digit index type (one of NUM_DIGITS slots)
    typedef logic [1:0] digit_idx_t;

    // Everything that is frozen for one frame so the display never tears
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_mask;
        logic [3:0]  blank_mask;
        logic        lz_en;
    } snap_t;

    // Active-low anode pattern with only the selected digit driven
    function automatic logic [3:0] an_select(input digit_idx_t idx);
        logic [3:0] an;
        an      = AN_OFF;
        an[idx] = 1'b0;
        return an;
    endfunction

endpackage : seg7_scan_driver_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_hex_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decoder
//  Purpose  : Combinational 4-bit nibble to active-low seven-segment glyph.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Map each hex value to its glyph; the case is full so no latch can form
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule : seg7_hex_decoder
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexes a 4-digit common-anode seven-segment display
//             from the system clock using a slot counter (no derived clock).
//             Inputs are snapshotted once per frame; supports per-digit
//             decimal points, blanking, leading-zero suppression and an
//             all-off guard interval at the start of every slot.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,  // clk_in cycles per digit slot
    parameter int GUARD_CYCLES = 2000     // all-off cycles at slot start
)
(
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam digit_idx_t       IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic             primed_q, primed_d;
    snap_t            snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_start_q, frame_start_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_cnt_wrap;
    logic             w_capture;
    logic             w_guard;
    logic [3:0]       w_dark;
    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;

    assign w_cnt_wrap = (cnt_q == CNT_LAST);
    assign w_guard    = (cnt_q < GUARD_END);

    // A capture happens on the first edge out of reset and at every frame
    // boundary, i.e. when the last slot of the last digit ends.
    assign w_capture  = ~primed_q | (w_cnt_wrap & (idx_q == IDX_LAST));

    // Digit0 honours only its blank bit; leading-zero suppression never
    // darkens it so a zero value still shows a single "0".
    assign w_dark[0] = snap_q.blank_mask[0];

    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_dark
        assign w_dark[gi] = snap_q.blank_mask[gi]
                          | (snap_q.lz_en & (snap_q.value[15:4*gi] == '0));
    end

    // Only the nibble of the digit currently in its slot is decoded
    assign w_nibble = snap_q.value[{idx_q, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .nibble (w_nibble),
        .seg    (w_glyph)
    );

    // ------------------------------------------------------------------
    // Slot counter and digit index: idx advances when a slot expires
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (w_cnt_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + digit_idx_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot: all display inputs are sampled together
    // ------------------------------------------------------------------
    always_comb begin
        primed_d      = 1'b1;
        snap_d        = snap_q;
        frame_start_d = w_capture;
        if (w_capture) begin
            snap_d.value      = value;
            snap_d.dp_mask    = dp_mask;
            snap_d.blank_mask = blank_mask;
            snap_d.lz_en      = lz_en;
        end
    end

    // ------------------------------------------------------------------
    // Display drive: dark during guard time and for dark digits, otherwise
    // one anode with its glyph and decimal point
    // ------------------------------------------------------------------
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        dp_n_d = 1'b1;
        if (!w_guard && !w_dark[idx_q]) begin
            an_d   = an_select(idx_q);
            seg_d  = w_glyph;
            dp_n_d = ~snap_q.dp_mask[idx_q];
        end
    end

    // ------------------------------------------------------------------
    // State register with asynchronous reset forcing the display dark
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            primed_q      <= 1'b0;
            snap_q        <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            primed_q      <= primed_d;
            snap_q        <= snap_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver (SCAN_DIV=8,
//             GUARD_CYCLES=2) with a cycle-count based reference model and
//             directed frame-level expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.SCAN_DIV(SD), .GUARD_CYCLES(GD)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: outputs follow from the number of edges since
    // reset release e; the output after edge e+1 reflects position e.
    // ------------------------------------------------------------------
    function automatic logic [11:0] model_out(input int e, input logic [15:0] v,
                                              input logic [3:0] dpm, input logic [3:0] blm,
                                              input logic lz);
        int         cnt;
        int         idx;
        logic [15:0] upper;
        logic       dark;
        logic [3:0] anv;
        cnt   = e % SD;
        idx   = (e / SD) % 4;
        upper = v >> (4 * idx);
        dark  = blm[idx] || (lz && idx >= 1 && upper == 16'd0);
        if (cnt < GD || dark) return {4'hF, 7'h7F, 1'b1};
        anv = 4'hF;
        anv[idx] = 1'b0;
        return {anv, GLYPH[v[4*idx +: 4]], ~dpm[idx]};
    endfunction

    int          m_e;
    logic [15:0] m_v;
    logic [3:0]  m_dp, m_bl;
    logic        m_lz;
    logic [11:0] exp_out;
    logic        exp_fs;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e     <= 0;
            m_v     <= '0;
            m_dp    <= '0;
            m_bl    <= '0;
            m_lz    <= 1'b0;
            exp_out <= {4'hF, 7'h7F, 1'b1};
            exp_fs  <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            exp_out <= model_out(m_e, m_v, m_dp, m_bl, m_lz);
            exp_fs  <= (m_e == 0) || ((m_e + 1) % FRAME == 0);
            if ((m_e == 0) || ((m_e + 1) % FRAME == 0)) begin
                m_v  <= value;
                m_dp <= dp_mask;
                m_bl <= blank_mask;
                m_lz <= lz_en;
            end
            m_e     <= m_e + 1;
            m_valid <= 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid && !rst) begin
            check("model_outputs", {19'd0, an, seg, dp_n, frame_start}, {19'd0, exp_out, exp_fs});
            check("anode_overlap", 32'((an[0] == 1'b0) + (an[1] == 1'b0) + (an[2] == 1'b0) + (an[3] == 1'b0) <= 1), 32'd1);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    logic [3:0] rec_an  [FRAME];
    logic [6:0] rec_seg [FRAME];
    logic       rec_dp  [FRAME];
    logic       rec_fs  [FRAME];

    task automatic sync_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        check("sync_frame", 32'(frame_start), 32'd1);
    endtask

    // Records the 32 output cycles that follow a frame_start cycle; the
    // last recorded cycle is the next frame_start cycle.
    task automatic record_frame(input int change_at, input logic [15:0] newv);
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            rec_an[j]  = an;
            rec_seg[j] = seg;
            rec_dp[j]  = dp_n;
            rec_fs[j]  = frame_start;
            if (j == change_at) value = newv;
        end
    endtask

    function automatic int low_count(input int d);
        int n = 0;
        logic [3:0] pat;
        pat = 4'hF;
        pat[d] = 1'b0;
        for (int j = 0; j < FRAME; j++) if (rec_an[j] == pat) n++;
        return n;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [3:0] pat;
        pat = 4'hF;
        pat[d] = 1'b0;
        for (int j = 0; j < FRAME; j++) if (rec_an[j] == pat) return rec_seg[j];
        return 7'h7F;
    endfunction

    function automatic int off_count();
        int n = 0;
        for (int j = 0; j < FRAME; j++) if (rec_an[j] == 4'hF) n++;
        return n;
    endfunction

    function automatic int fs_count();
        int n = 0;
        for (int j = 0; j < FRAME; j++) if (rec_fs[j]) n++;
        return n;
    endfunction

    task automatic release_and_first_lit();
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (an == 4'hF && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("first_lit_edge", n, 3);
        check("first_lit_an", 32'(an), 32'hE);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_an"},  32'(an),          32'hF);
        check({tag, "_seg"}, 32'(seg),         32'h7F);
        check({tag, "_dp"},  32'(dp_n),        32'd1);
        check({tag, "_fs"},  32'(frame_start), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b0;
        value      = 16'h1234;
        dp_mask    = 4'h0;
        blank_mask = 4'h0;
        lz_en      = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset_init");
        release_and_first_lit();

        // Normal scan of 1234
        sync_frame();
        record_frame(-1, 16'h0);
        check("d0_seg", 32'(seg_of(0)), 32'h19);
        check("d1_seg", 32'(seg_of(1)), 32'h30);
        check("d2_seg", 32'(seg_of(2)), 32'h24);
        check("d3_seg", 32'(seg_of(3)), 32'h79);
        for (int d = 0; d < 4; d++) check("low_cycles", low_count(d), 6);
        check("guard_cycles", off_count(), 8);
        check("frame_period", fs_count() * 100 + (rec_fs[FRAME-1] ? 1 : 0), 101);

        // Snapshot: change during slot1 only takes effect next frame
        record_frame(10, 16'hABCD);
        check("snap_d0_old", 32'(seg_of(0)), 32'h19);
        check("snap_d1_old", 32'(seg_of(1)), 32'h30);
        check("snap_d2_old", 32'(seg_of(2)), 32'h24);
        check("snap_d3_old", 32'(seg_of(3)), 32'h79);
        record_frame(-1, 16'h0);
        check("snap_d0_new", 32'(seg_of(0)), 32'h21);
        check("snap_d1_new", 32'(seg_of(1)), 32'h46);
        check("snap_d2_new", 32'(seg_of(2)), 32'h03);
        check("snap_d3_new", 32'(seg_of(3)), 32'h08);

        // Leading-zero suppression
        value = 16'h0050;
        lz_en = 1'b1;
        record_frame(-1, 16'h0);
        record_frame(-1, 16'h0);
        check("lz_d3_dark", low_count(3), 0);
        check("lz_d2_dark", low_count(2), 0);
        check("lz_d1_seg", 32'(seg_of(1)), 32'h12);
        check("lz_d0_seg", 32'(seg_of(0)), 32'h40);
        check("lz_d1_low", low_count(1), 6);
        value = 16'h0000;
        record_frame(-1, 16'h0);
        record_frame(-1, 16'h0);
        check("lz0_d1_dark", low_count(1), 0);
        check("lz0_d2_dark", low_count(2), 0);
        check("lz0_d3_dark", low_count(3), 0);
        check("lz0_d0_seg", 32'(seg_of(0)), 32'h40);

        // Decimal point and blanking masks
        value      = 16'h1234;
        lz_en      = 1'b0;
        dp_mask    = 4'b0100;
        blank_mask = 4'b0001;
        record_frame(-1, 16'h0);
        record_frame(-1, 16'h0);
        begin
            int dp_low = 0;
            int dp_bad = 0;
            for (int j = 0; j < FRAME; j++) begin
                if (!rec_dp[j]) dp_low++;
                if (!rec_dp[j] && rec_an[j] != 4'b1011) dp_bad++;
            end
            check("dp_low_cycles", dp_low, 6);
            check("dp_only_digit2", dp_bad, 0);
        end
        check("blank_d0", low_count(0), 0);
        check("mask_frame_period", fs_count() * 100 + (rec_fs[FRAME-1] ? 1 : 0), 101);

        // Asynchronous reset in the middle of slot1
        dp_mask    = 4'h0;
        blank_mask = 4'h0;
        record_frame(-1, 16'h0);
        repeat (13) @(negedge clk);
        check("pre_reset_an", 32'(an), 32'hD);
        #2 rst = 1'b1;
        #1 check_reset_state("reset_async");
        release_and_first_lit();

        // Random traffic; the model and overlap checks run every cycle
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            value      = 16'($urandom);
            dp_mask    = 4'($urandom);
            blank_mask = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            lz_en      = 1'($urandom);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
